// File: rtl/param_seq_divider.sv
// param_seq_divider: WIDTH-bit restoring divider (one quotient bit per clk, Busy/Rdy handshake, divide-by-zero flag).
// Optional two's-complement mode is built only when PSD_SIGNED_EN is defined.
module param_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dvnd,
  input  logic [WIDTH-1:0] Dvsr,
  input  logic             Signed,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             Rdy,
  output logic             Busy,
  output logic             DivZero
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvsr;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0] shifted, trial;
  logic zero, zero_in, accept, ge;
`ifdef PSD_SIGNED_EN
  logic a_neg, b_neg, neg_q, neg_r;
  assign a_neg = Signed & Dvnd[WIDTH-1];
  assign b_neg = Signed & Dvsr[WIDTH-1];
  assign a_mag = a_neg ? -Dvnd : Dvnd;
  assign b_mag = b_neg ? -Dvsr : Dvsr;
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;
  always_ff @(posedge clk or posedge Rst)
    if (Rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
`else
  logic unused_signed;
  assign unused_signed = Signed;
  assign a_mag = Dvnd;
  assign b_mag = Dvsr;
  assign q_fix = quo;
  assign r_fix = rem;
`endif
  assign accept  = Run && (state == IDLE || state == DONE);
  assign zero_in = (Dvsr == '0);
  assign shifted = {rem, quo[WIDTH-1]};
  assign ge      = shifted >= {1'b0, dvsr};
  assign trial   = shifted - {1'b0, dvsr};
  always_ff @(posedge clk or posedge Rst)
    if (Rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = zero_in ? FIX : CALC;
    else if (state == CALC) state_nxt = (cnt == CNT_W'(1)) ? FIX : CALC;
    else if (state == FIX) state_nxt = DONE;
  end
  // On divide-by-zero quo keeps the raw dividend so FIX can return it as R.
  always_ff @(posedge clk or posedge Rst)
    if (Rst) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      zero    <= 1'b0;
      Q       <= '0;
      R       <= '0;
      Rdy     <= 1'b0;
      Busy    <= 1'b0;
      DivZero <= 1'b0;
    end else if (accept) begin
      cnt     <= CNT_W'(WIDTH);
      rem     <= '0;
      quo     <= zero_in ? Dvnd : a_mag;
      dvsr    <= b_mag;
      zero    <= zero_in;
      Rdy     <= 1'b0;
      Busy    <= 1'b1;
      DivZero <= 1'b0;
    end else if (state == CALC) begin
      cnt <= cnt - CNT_W'(1);
      rem <= ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], ge};
    end else if (state == FIX) begin
      Q       <= zero ? '1 : q_fix;
      R       <= zero ? quo : r_fix;
      DivZero <= zero;
      Rdy     <= 1'b1;
      Busy    <= 1'b0;
    end
endmodule

// File: tb/tb_param_seq_divider.sv
// tb_param_seq_divider: randomized self-checking bench for param_seq_divider (WIDTH=32 and WIDTH=8 instances).
module tb_param_seq_divider;
`ifdef PSD_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  logic clk = 0, rst = 0, run = 0, sgn = 0;
  logic [31:0] dvnd = 0, dvsr = 0, q, r;
  logic rdy, busy, dz;
  logic run8 = 0;
  logic [7:0] a8 = 0, b8 = 0, q8, r8;
  logic rdy8, busy8, dz8;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  param_seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .Rst(rst), .Run(run), .Dvnd(dvnd), .Dvsr(dvsr), .Signed(sgn),
    .Q(q), .R(r), .Rdy(rdy), .Busy(busy), .DivZero(dz)
  );
  param_seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .Rst(rst), .Run(run8), .Dvnd(a8), .Dvsr(b8), .Signed(1'b0),
    .Q(q8), .R(r8), .Rdy(rdy8), .Busy(busy8), .DivZero(dz8)
  );
  function automatic void model(input logic [31:0] a, b, input logic s,
                                output logic [31:0] eq, er, output logic ez);
    ez = (b == 0);
    if (b == 0) begin
      eq = '1;
      er = a;
    end else if (s && SIGNED_EN) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        eq = a;
        er = 0;
      end else begin
        eq = $signed(a) / $signed(b);
        er = $signed(a) % $signed(b);
      end
    end else begin
      eq = a / b;
      er = a % b;
    end
  endfunction
  task automatic run_op(input logic [31:0] a, b, input logic s,
                        output logic [31:0] oq, orr, output logic oz, ordy, obusy, output int lat);
    @(negedge clk);
    dvnd = a; dvsr = b; sgn = s; run = 1;
    @(posedge clk); #1;
    run = 0; obusy = busy; lat = 1;
    while (!rdy && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    oq = q; orr = r; oz = dz; ordy = rdy;
  endtask
  task automatic test_reset;
    #2 rst = 1;
    #1;
    checks++;
    if ({q, r, rdy, busy, dz} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state: Q=%h R=%h Rdy=%b Busy=%b DivZero=%b, expected all zero", q, r, rdy, busy, dz);
    end
    @(negedge clk) rst = 0;
  endtask
  task automatic test_basic;
    logic [31:0] oq, orr; logic oz, ordy, ob; int lat;
    run_op(100, 7, 0, oq, orr, oz, ordy, ob, lat);
    checks++;
    if (oq !== 14 || orr !== 2 || oz !== 0 || ordy !== 1) begin
      errors++;
      $display("FAIL basic_100_7: Q=%0d R=%0d DivZero=%b Rdy=%b, expected 14 2 0 1", oq, orr, oz, ordy);
    end
    checks++;
    if (lat != 34 || ob !== 1) begin
      errors++;
      $display("FAIL basic_latency: Rdy at edge %0d busy=%b, expected edge 34 busy=1", lat, ob);
    end
  endtask
  task automatic test_divzero;
    logic [31:0] oq, orr; logic oz, ordy, ob; int lat;
    run_op(32'h1234, 0, 0, oq, orr, oz, ordy, ob, lat);
    checks++;
    if (oq !== 32'hFFFF_FFFF || orr !== 32'h1234 || oz !== 1 || lat != 2) begin
      errors++;
      $display("FAIL divzero: Q=%h R=%h DivZero=%b edge=%0d, expected ffffffff 00001234 1 2", oq, orr, oz, lat);
    end
  endtask
  task automatic test_hold;
    int lat;
    logic [31:0] eq, er; logic ez;
    @(negedge clk);
    dvnd = 1000; dvsr = 3; sgn = 0; run = 1;
    @(posedge clk); #1;
    run = 0; lat = 1;
    repeat (20) begin
      @(posedge clk); #1;
      lat++;
      if (lat % 5 == 0) begin
        checks++;
        if (q !== 32'h0 + 32'd14 || r !== 2) begin
          errors++;
          $display("FAIL hold_prev: edge %0d Q=%0d R=%0d, expected 14 2", lat, q, r);
        end
      end
    end
    while (!rdy && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    model(1000, 3, 0, eq, er, ez);
    checks++;
    if (q !== eq || r !== er || lat != 34) begin
      errors++;
      $display("FAIL hold_next: Q=%0d R=%0d edge=%0d, expected %0d %0d 34", q, r, lat, eq, er);
    end
  endtask
  task automatic test_ignore_run;
    int lat;
    logic [31:0] eq, er; logic ez;
    @(negedge clk);
    dvnd = 32'hDEAD_BEEF; dvsr = 32'h1234; sgn = 0; run = 1;
    @(posedge clk); #1;
    run = 0; lat = 1;
    repeat (4) begin
      @(posedge clk); #1;
      lat++;
    end
    run = 1; dvnd = 7; dvsr = 0;
    @(posedge clk); #1;
    lat++; run = 0;
    while (!rdy && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    model(32'hDEAD_BEEF, 32'h1234, 0, eq, er, ez);
    checks++;
    if (q !== eq || r !== er || dz !== 0 || lat != 34) begin
      errors++;
      $display("FAIL ignore_run: Q=%h R=%h DivZero=%b edge=%0d, expected %h %h 0 34", q, r, dz, lat, eq, er);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdy !== 1 || busy !== 0) begin
      errors++;
      $display("FAIL ignore_idle: Rdy=%b Busy=%b, expected 1 0", rdy, busy);
    end
  endtask
  task automatic test_abort;
    logic [31:0] oq, orr; logic oz, ordy, ob; int lat;
    @(negedge clk);
    dvnd = 32'h7777_0000; dvsr = 5; sgn = 0; run = 1;
    @(posedge clk); #1;
    run = 0;
    repeat (9) @(posedge clk);
    @(negedge clk); #2;
    rst = 1;
    #1;
    checks++;
    if ({q, r, rdy, busy, dz} !== 67'd0) begin
      errors++;
      $display("FAIL abort_reset: Q=%h R=%h Rdy=%b Busy=%b DivZero=%b, expected all zero", q, r, rdy, busy, dz);
    end
    @(negedge clk) rst = 0;
    run_op(32'hFFFF_FFFF, 1, 0, oq, orr, oz, ordy, ob, lat);
    checks++;
    if (oq !== 32'hFFFF_FFFF || orr !== 0 || oz !== 0 || lat != 34) begin
      errors++;
      $display("FAIL abort_next: Q=%h R=%h DivZero=%b edge=%0d, expected ffffffff 0 0 34", oq, orr, oz, lat);
    end
  endtask
  task automatic test_back_to_back;
    int lat;
    logic [31:0] eq, er; logic ez;
    @(negedge clk);
    dvnd = 32'h0012_3456; dvsr = 77; sgn = 0; run = 1;
    @(posedge clk); #1;
    lat = 1;
    while (!rdy && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    model(32'h0012_3456, 77, 0, eq, er, ez);
    checks++;
    if (q !== eq || r !== er || lat != 34) begin
      errors++;
      $display("FAIL b2b_first: Q=%h R=%h edge=%0d, expected %h %h 34", q, r, lat, eq, er);
    end
    dvnd = 32'hCAFE_F00D; dvsr = 32'h0001_0001;
    @(posedge clk); #1;
    checks++;
    if (rdy !== 0 || busy !== 1) begin
      errors++;
      $display("FAIL b2b_restart: Rdy=%b Busy=%b, expected 0 1", rdy, busy);
    end
    run = 0; lat = 1;
    while (!rdy && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    model(32'hCAFE_F00D, 32'h0001_0001, 0, eq, er, ez);
    checks++;
    if (q !== eq || r !== er || lat != 34) begin
      errors++;
      $display("FAIL b2b_second: Q=%h R=%h edge=%0d, expected %h %h 34", q, r, lat, eq, er);
    end
  endtask
  task automatic test_random;
    logic [31:0] a, b, oq, orr, eq, er; logic s, oz, ordy, ob, ez; int lat;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = $urandom_range(1, 15);
        2: b = $urandom;
        default: b = a >> $urandom_range(1, 31);
      endcase
      s = 1'($urandom_range(0, 1));
      run_op(a, b, s, oq, orr, oz, ordy, ob, lat);
      model(a, b, s, eq, er, ez);
      checks++;
      if (oq !== eq || orr !== er || oz !== ez) begin
        errors++;
        $display("FAIL rand_result: %h/%h s=%b Q=%h R=%h DZ=%b, expected %h %h %b", a, b, s, oq, orr, oz, eq, er, ez);
      end
      checks++;
      if (lat != (ez ? 2 : 34) || ob !== 1) begin
        errors++;
        $display("FAIL rand_latency: %h/%h edge=%0d busy=%b, expected edge %0d busy=1", a, b, lat, ob, ez ? 2 : 34);
      end
    end
  endtask
`ifdef PSD_SIGNED_EN
  task automatic test_signed;
    logic [31:0] oq, orr; logic oz, ordy, ob; int lat;
    run_op(-32'sd7, 2, 1, oq, orr, oz, ordy, ob, lat);
    checks++;
    if (oq !== 32'hFFFF_FFFD || orr !== 32'hFFFF_FFFF || oz !== 0) begin
      errors++;
      $display("FAIL signed_m7_2: Q=%h R=%h DZ=%b, expected fffffffd ffffffff 0", oq, orr, oz);
    end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1, oq, orr, oz, ordy, ob, lat);
    checks++;
    if (oq !== 32'h8000_0000 || orr !== 0 || oz !== 0) begin
      errors++;
      $display("FAIL signed_min_m1: Q=%h R=%h DZ=%b, expected 80000000 0 0", oq, orr, oz);
    end
    run_op(-32'sd100, 0, 1, oq, orr, oz, ordy, ob, lat);
    checks++;
    if (oq !== 32'hFFFF_FFFF || orr !== 32'hFFFF_FF9C || oz !== 1) begin
      errors++;
      $display("FAIL signed_divzero: Q=%h R=%h DZ=%b, expected ffffffff ffffff9c 1", oq, orr, oz);
    end
  endtask
`endif
  task automatic test_width8;
    logic [7:0] a, b, eq, er; int lat;
    for (int i = 0; i < 12; i++) begin
      a = (i == 0) ? 8'd200 : 8'($urandom);
      b = (i == 0) ? 8'd3 : (i == 1) ? 8'd0 : 8'($urandom);
      eq = (b == 0) ? 8'hFF : a / b;
      er = (b == 0) ? a : a % b;
      @(negedge clk);
      a8 = a; b8 = b; run8 = 1;
      @(posedge clk); #1;
      run8 = 0; lat = 1;
      while (!rdy8 && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (q8 !== eq || r8 !== er || dz8 !== (b == 0) || lat != ((b == 0) ? 2 : 10)) begin
        errors++;
        $display("FAIL w8_div: %0d/%0d Q=%0d R=%0d DZ=%b edge=%0d, expected %0d %0d %b %0d",
                 a, b, q8, r8, dz8, lat, eq, er, b == 0, (b == 0) ? 2 : 10);
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_divzero();
    test_basic();
    test_hold();
    test_ignore_run();
    test_abort();
    test_back_to_back();
    test_random();
`ifdef PSD_SIGNED_EN
    test_signed();
`endif
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
